// File: rtl/ps2_char_input.sv
// PS/2 keyboard front end: frame receiver, make-code decoder, character FIFO
// and paced newchar/char delivery toward the processor.
module ps2_char_input #(
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        newchar,
    output logic [15:0] char,
    output logic        overflow,
    output logic        frame_err
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;
    logic       fall;
    logic       bit_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    state_t        state, state_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_bit, par_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          byte_ok;
    logic          err;
    logic          tmo_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tmo     <= '0;
        end else begin
            state   <= state_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            tmo     <= tmo_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par_bit;
        tmo_n    = '0;
        byte_ok  = 1'b0;
        err      = 1'b0;
        tmo_hit  = 1'b0;
        if (state != IDLE && !fall) begin
            tmo_n   = tmo + 1'b1;
            tmo_hit = (tmo_n == TMO_MAX);
        end
        unique case (state)
            IDLE: begin
                if (fall && !bit_in) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n  = {bit_in, shreg[7:1]};
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = bit_in;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    // odd parity over data plus parity bit
                    if (bit_in && (^shreg ^ par_bit)) byte_ok = 1'b1;
                    else err = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (tmo_hit) begin
            state_n = IDLE;
            tmo_n   = '0;
            err     = 1'b1;
        end
    end

    logic        ext, ext_n;
    logic        brk, brk_n;
    logic        push;
    logic [15:0] push_data;

    always_comb begin
        ext_n     = ext;
        brk_n     = brk;
        push      = 1'b0;
        push_data = {(ext ? 8'hE0 : 8'h00), shreg};
        if (tmo_hit) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end else if (byte_ok) begin
            if (shreg == 8'hE0) begin
                ext_n = 1'b1;
            end else if (shreg == 8'hF0) begin
                brk_n = 1'b1;
            end else if (brk) begin
                ext_n = 1'b0;
                brk_n = 1'b0;
            end else begin
                push  = 1'b1;
                ext_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else begin
            ext <= ext_n;
            brk <= brk_n;
        end
    end

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [GW-1:0] gap;
    logic          full, empty, pop, push_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign pop     = !empty && (gap == '0);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wp <= AW'((32'(wp) + 1) % FIFO_DEPTH);
            if (pop) rp <= AW'((32'(rp) + 1) % FIFO_DEPTH);
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            newchar   <= 1'b0;
            char      <= '0;
            gap       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
            newchar   <= pop;
            if (pop) begin
                char <= mem[rp];
                gap  <= GAP_LOAD;
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_char_input.sv
// Bench for ps2_char_input: vector table, overflow, timeout and reset
// sequences, then random frames against a make/break/extended model.
module tb_ps2_char_input;

    localparam int GAP  = 600;
    localparam int TMO  = 5000;
    localparam int HALF = 4;
    localparam int WAIT = 700;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        newchar;
    logic [15:0] char;
    logic        overflow;
    logic        frame_err;

    ps2_char_input #(
        .FIFO_DEPTH(4),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .newchar(newchar),
        .char(char),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nc_cnt = 0;
    int err_cnt = 0;
    int first_nc = -1;
    int last_nc = -1;
    int err_cyc = -1;
    int last_fall = 0;
    logic [15:0] obs[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && newchar) begin
            obs.push_back(char);
            nc_cnt++;
            if (first_nc < 0) first_nc = cyc;
            if (last_nc >= 0) begin
                total++;
                if (cyc - last_nc < GAP) begin
                    bad++;
                    $display("FAIL spacing: got %0d cycles, need >= %0d",
                             cyc - last_nc, GAP);
                end
            end
            last_nc = cyc;
        end
        if (rst && frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pf,
                              input bit sb);
        logic par;
        par = (~^b) ^ pf;
        send_bits({sb, par, b, 1'b0}, 11);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] b,
                             input bit pf, input bit sb, input int enc,
                             input logic [15:0] ech, input int eerr);
        nc_cnt = 0;
        err_cnt = 0;
        first_nc = -1;
        send_frame(b, pf, sb);
        repeat (WAIT) @(negedge clk);
        chk({nm, " newchar"}, nc_cnt, enc);
        chk({nm, " char"}, char, ech);
        chk({nm, " frame_err"}, err_cnt, eerr);
        if (enc == 1 && nc_cnt == 1)
            chk({nm, " latency"}, first_nc - last_fall, 4);
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          pf;
        bit          sb;
        int          nc;
        logic [15:0] ch;
        int          err;
    } vec_t;

    vec_t tbl[13];

    logic [15:0] exp_q[5];
    logic [7:0]  rb;
    bit          m_ext, m_brk, rpf, rsb;
    int          enc, eerr, waited;
    logic [15:0] cur;

    initial begin
        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1, 16'h001C, 0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b1, 0, 16'h001C, 0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b1, 0, 16'h001C, 0};
        tbl[3]  = '{8'h1C, 1'b0, 1'b1, 1, 16'h001C, 0};
        tbl[4]  = '{8'hE0, 1'b0, 1'b1, 0, 16'h001C, 0};
        tbl[5]  = '{8'h75, 1'b0, 1'b1, 1, 16'hE075, 0};
        tbl[6]  = '{8'hE0, 1'b0, 1'b1, 0, 16'hE075, 0};
        tbl[7]  = '{8'hF0, 1'b0, 1'b1, 0, 16'hE075, 0};
        tbl[8]  = '{8'h75, 1'b0, 1'b1, 0, 16'hE075, 0};
        tbl[9]  = '{8'h1C, 1'b0, 1'b1, 1, 16'h001C, 0};
        tbl[10] = '{8'h1C, 1'b1, 1'b1, 0, 16'h001C, 1};
        tbl[11] = '{8'h1C, 1'b0, 1'b0, 0, 16'h001C, 1};
        tbl[12] = '{8'h74, 1'b0, 1'b1, 1, 16'h0074, 0};

        repeat (3) @(negedge clk);
        chk("rst newchar", newchar, 0);
        chk("rst char", char, 0);
        chk("rst overflow", overflow, 0);
        chk("rst frame_err", frame_err, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        foreach (tbl[i])
            run_frame($sformatf("vec%0d", i), tbl[i].b, tbl[i].pf,
                      tbl[i].sb, tbl[i].nc, tbl[i].ch, tbl[i].err);
        chk("no overflow yet", overflow, 0);

        // six frames back to back: first pops, four queue, sixth dropped
        obs.delete();
        exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
        send_frame(8'h11, 0, 1);
        send_frame(8'h22, 0, 1);
        send_frame(8'h33, 0, 1);
        send_frame(8'h44, 0, 1);
        send_frame(8'h55, 0, 1);
        send_frame(8'h66, 0, 1);
        repeat (10) @(negedge clk);
        chk("ovf set", overflow, 1);
        repeat (5 * GAP + 200) @(negedge clk);
        chk("ovf count", obs.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < obs.size())
                chk($sformatf("ovf order%0d", i), obs[i], exp_q[i]);
        chk("ovf sticky", overflow, 1);

        // partial frame: start plus four data bits, then silence
        err_cnt = 0;
        send_bits({3'b111, 8'h0C, 1'b0}, 5);
        waited = 0;
        while (err_cnt == 0 && waited < TMO + 50) begin
            @(negedge clk);
            waited++;
        end
        chk("tmo fired", err_cnt, 1);
        if (err_cnt > 0) chk("tmo delay", err_cyc - last_fall, TMO + 3);
        run_frame("after tmo", 8'h1C, 0, 1, 1, 16'h001C, 0);

        // reset with one char queued and a frame in progress
        send_frame(8'h1C, 0, 1);
        send_frame(8'h32, 0, 1);
        send_bits({3'b111, 8'h5A, 1'b0}, 4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid rst newchar", newchar, 0);
        chk("mid rst char", char, 0);
        chk("mid rst overflow", overflow, 0);
        chk("mid rst frame_err", frame_err, 0);
        repeat (4) @(negedge clk);
        last_nc = -1;
        rst = 1'b1;
        nc_cnt = 0;
        repeat (WAIT) @(negedge clk);
        chk("queue flushed", nc_cnt, 0);
        run_frame("after rst", 8'h1C, 0, 1, 1, 16'h001C, 0);

        // random frames against the make/break/extended model
        m_ext = 0;
        m_brk = 0;
        cur = 16'h001C;
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 12) rb = 8'hE0;
            else if (r < 24) rb = 8'hF0;
            else begin
                rb = 8'($urandom_range(0, 255));
                if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h2B;
            end
            rpf = 0;
            rsb = 1;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) rpf = 1;
                else rsb = 0;
            end
            enc = 0;
            eerr = 0;
            if (rpf || !rsb) eerr = 1;
            else if (rb == 8'hE0) m_ext = 1;
            else if (rb == 8'hF0) m_brk = 1;
            else if (m_brk) begin
                m_ext = 0;
                m_brk = 0;
            end else begin
                enc = 1;
                cur = {m_ext ? 8'hE0 : 8'h00, rb};
                m_ext = 0;
            end
            run_frame($sformatf("rnd%0d", i), rb, rpf, rsb, enc, cur, eerr);
        end
        chk("rnd overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
